// File: rtl/rq_ack_pkg.sv
// Shared FSM state encoding and default sizing for the product accumulator.
// No logic; constants only.
package rq_ack_pkg;

    localparam logic [1:0] ST_ACCUM        = 2'd0;
    localparam logic [1:0] ST_SEND         = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK_LOW = 2'd2;

    localparam int DEF_ACKDATA_WIDTH = 16;
    localparam int DEF_SUM_WIDTH     = 24;
    localparam int DEF_BATCH_LEN     = 4;

endpackage

// File: rtl/reg_produs_tampon.sv
// One-entry holding register for a product that arrives while a batch is being handed off.
// Load/consume take effect on the next edge; the caller decides what to do when full.
module reg_produs_tampon #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             consume,
    input  logic [WIDTH-1:0] product,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= product;
        end else if (consume) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/acumulator_produse_rq_ack.sv
// Sums BATCH_LEN products, then offers the sum on a four-phase req/ack handshake (req one cycle after last product).
// Products during the handshake go to a one-entry buffer; overflow sets sticky drop. ACUM_SATURARE_EN selects saturating sum.
module acumulator_produse_rq_ack
    import rq_ack_pkg::*;
#(
    parameter int ACKDATA_WIDTH = DEF_ACKDATA_WIDTH,
    parameter int SUM_WIDTH     = DEF_SUM_WIDTH,
    parameter int BATCH_LEN     = DEF_BATCH_LEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid,
    input  logic [ACKDATA_WIDTH-1:0] result,
    output logic                     req,
    input  logic                     ack,
    output logic [SUM_WIDTH-1:0]     req_data,
    output logic [7:0]               count,
    output logic                     drop
);

    localparam logic [7:0] BATCH_CNT = 8'(BATCH_LEN);

    logic [1:0]               state;
    logic [SUM_WIDTH-1:0]     sum;
    logic [SUM_WIDTH-1:0]     sum_next;
    logic [SUM_WIDTH-1:0]     hold_ext;
    logic [SUM_WIDTH-1:0]     result_ext;
    logic [ACKDATA_WIDTH-1:0] hold_data;
    logic                     hold_full;
    logic                     hold_load;
    logic                     hold_consume;
    logic                     in_accum;
    logic                     take_valid;
    logic [1:0]               inc;
    logic [7:0]               count_next;

    reg_produs_tampon #(
        .WIDTH(ACKDATA_WIDTH)
    ) u_tampon (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (hold_load),
        .consume (hold_consume),
        .product (result),
        .full    (hold_full),
        .data    (hold_data)
    );

    // The buffer can only be full on ACCUM entry, so consuming whenever full in ACCUM
    // is exactly "first product of the next batch", possibly alongside a live valid.
    always_comb begin
        in_accum     = (state == ST_ACCUM);
        take_valid   = in_accum && valid;
        hold_consume = in_accum && hold_full;
        hold_load    = valid && !in_accum && !hold_full;
        hold_ext     = hold_consume ? SUM_WIDTH'(hold_data) : '0;
        result_ext   = take_valid ? SUM_WIDTH'(result) : '0;
        inc          = {1'b0, hold_consume} + {1'b0, take_valid};
        count_next   = count + {6'd0, inc};
    end

`ifdef ACUM_SATURARE_EN
    logic [SUM_WIDTH+1:0] sum_ext;

    always_comb begin
        sum_ext  = {2'b00, sum} + {2'b00, hold_ext} + {2'b00, result_ext};
        sum_next = (|sum_ext[SUM_WIDTH+1:SUM_WIDTH]) ? '1 : sum_ext[SUM_WIDTH-1:0];
    end
`else
    always_comb begin
        sum_next = sum + hold_ext + result_ext;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ACCUM;
            sum      <= '0;
            count    <= '0;
            req      <= 1'b0;
            req_data <= '0;
            drop     <= 1'b0;
        end else begin
            if (valid && !in_accum && hold_full) begin
                drop <= 1'b1;
            end
            case (state)
                ST_ACCUM: begin
                    if (inc != 2'd0) begin
                        sum   <= sum_next;
                        count <= count_next;
                        if (count_next >= BATCH_CNT) begin
                            state    <= ST_SEND;
                            req      <= 1'b1;
                            req_data <= sum_next;
                        end
                    end
                end
                ST_SEND: begin
                    if (ack) begin
                        req   <= 1'b0;
                        state <= ST_WAIT_ACK_LOW;
                    end
                end
                ST_WAIT_ACK_LOW: begin
                    if (!ack) begin
                        sum   <= '0;
                        count <= '0;
                        state <= ST_ACCUM;
                    end
                end
                default: begin
                    state <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acumulator_produse_rq_ack.sv
// Directed bench: batch sums, handshake timing, holding buffer, drop, reset and overflow.
module tb_acumulator_produse_rq_ack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, ack, valid2, ack2;
    logic [15:0] result, result2;
    logic        req, req2, drop, drop2;
    logic [23:0] req_data;
    logic [15:0] req_data2;
    logic [7:0]  count, count2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    acumulator_produse_rq_ack dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .result   (result),
        .req      (req),
        .ack      (ack),
        .req_data (req_data),
        .count    (count),
        .drop     (drop)
    );

    acumulator_produse_rq_ack #(
        .ACKDATA_WIDTH (16),
        .SUM_WIDTH     (16),
        .BATCH_LEN     (4)
    ) dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid2),
        .result   (result2),
        .req      (req2),
        .ack      (ack2),
        .req_data (req_data2),
        .count    (count2),
        .drop     (drop2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [15:0] v);
        valid  = 1'b1;
        result = v;
        tick();
        valid  = 1'b0;
    endtask

    task automatic put2(input logic [15:0] v);
        valid2  = 1'b1;
        result2 = v;
        tick();
        valid2  = 1'b0;
    endtask

    task automatic handshake();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; ack = 1'b0; result = '0;
        valid2 = 1'b0; ack2 = 1'b0; result2 = '0;
        #12;
        check("rst_req", req, 0);
        check("rst_req_data", req_data, 0);
        check("rst_count", count, 0);
        check("rst_drop", drop, 0);
        tick();
        rst_n = 1'b1;

        // 3,5,7,9 with gaps -> 24
        put(16'd3);
        check("first_acc_count", count, 1);
        tick(); put(16'd5); tick(); put(16'd7);
        check("three_count", count, 3);
        check("three_no_req", req, 0);
        tick(); put(16'd9);
        check("b1_req", req, 1);
        check("b1_data", req_data, 24);
        check("b1_count", count, 4);
        tick(); tick();
        check("b1_req_hold", req, 1);
        check("b1_data_hold", req_data, 24);
        ack = 1'b1; tick();
        check("b1_req_drop", req, 0);
        ack = 1'b0; tick();
        check("b1_count_clear", count, 0);

        // ack high in ACCUM is ignored
        ack = 1'b1; put(16'd6); tick(); ack = 1'b0;
        check("ack_ign_count", count, 1);
        check("ack_ign_req", req, 0);
        put(16'd1); put(16'd1); put(16'd1);
        check("ack_ign_data", req_data, 9);
        handshake();

        // one product during SEND is held and starts the next batch
        put(16'd1); put(16'd2); put(16'd3); put(16'd4);
        check("b3_data", req_data, 10);
        put(16'd11);
        check("held_no_drop", drop, 0);
        handshake();
        check("held_entry_count", count, 0);
        tick();
        check("held_consumed_count", count, 1);
        check("held_drop", drop, 0);
        put(16'd1); put(16'd1); put(16'd1);
        check("held_batch_req", req, 1);
        check("held_batch_data", req_data, 14);

        // two products during SEND: second lost; entry cycle adds held + live
        put(16'd20); put(16'd30);
        check("drop_set", drop, 1);
        handshake();
        put(16'd5);
        check("dual_add_count", count, 2);
        put(16'd1);
        check("dual_cnt3", count, 3);
        check("dual_no_req", req, 0);
        put(16'd1);
        check("dual_req", req, 1);
        check("dual_data", req_data, 27);

        // ack held high through WAIT_ACK_LOW
        ack = 1'b1; tick();
        check("wal_req_low", req, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wal_req", req, 0);
            check("wal_count", count, 4);
        end
        ack = 1'b0; tick();
        check("wal_exit_count", count, 0);
        check("drop_sticky", drop, 1);

        // reset mid-handshake with a held product
        put(16'd1); put(16'd1); put(16'd1); put(16'd1);
        check("pre_rst_req", req, 1);
        put(16'd50);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", req, 0);
        check("async_rst_count", count, 0);
        check("async_rst_drop", drop, 0);
        check("async_rst_data", req_data, 0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("post_rst_count", count, 0);
        check("post_rst_req", req, 0);
        put(16'd2); put(16'd2); put(16'd2);
        check("post_rst_no_req", req, 0);
        check("post_rst_cnt3", count, 3);
        put(16'd2);
        check("post_rst_req_new", req, 1);
        check("post_rst_data", req_data, 8);
        handshake();

        // 16-bit accumulator overflow
        put2(16'hFFFF); put2(16'hFFFF); put2(16'hFFFF); put2(16'hFFFF);
        check("ovf_req", req2, 1);
        check("ovf_count", count2, 4);
        check("ovf_drop", drop2, 0);
`ifdef ACUM_SATURARE_EN
        check("ovf_data", req_data2, 32'h0000_FFFF);
`else
        check("ovf_data", req_data2, 32'h0000_FFFC);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
